// File: rtl/dot_product_ctrl.sv
// Beat-sequenced dot-product controller: accumulates reduction-tree sums over a
// job of `length` beats and hands back one 32-bit result over valid/ready.
module dot_product_ctrl #(
  parameter int N     = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      tree_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic [LEN_W+7:0] elem_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a beat transfers when s_valid & s_ready at a rising edge; a result
  // transfers when out_valid & out_ready. Neither ready depends on its valid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  localparam int EW = LEN_W + 8;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic             r_ovf;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_beats;
  logic [31:0]      r_out_sum;
  logic             r_out_ovf;

  logic             w_hs;
  logic [32:0]      w_add;
  logic             w_ovf_next;
  logic [EW-1:0]    w_beats_ext;
  logic [EW-1:0]    w_elem;

  assign w_hs       = s_valid & (r_state == S_ACCUM);
  assign w_add      = {1'b0, r_acc} + {1'b0, tree_sum};
  assign w_ovf_next = r_ovf | w_add[32];

  assign w_beats_ext = EW'(r_beats);

  generate
    if ((N & (N - 1)) == 0) begin : g_shift
      assign w_elem = w_beats_ext << $clog2(N);
    end else begin : g_mult
      assign w_elem = w_beats_ext * EW'(N);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort outranks start even though it has nothing to cancel here
          if (start && !abort) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_beats     <= '0;
            r_remaining <= length;
            if (length == '0) begin
              r_out_sum <= '0;
              r_out_ovf <= 1'b0;
              r_state   <= S_OUTPUT;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (abort) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_acc       <= w_add[31:0];
            r_ovf       <= w_ovf_next;
            r_remaining <= r_remaining - 1'b1;
            r_beats     <= r_beats + 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_out_sum <= w_add[31:0];
              r_out_ovf <= w_ovf_next;
              r_state   <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (abort) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
          end else if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign s_ready    = (r_state == S_ACCUM);
  assign out_valid  = (r_state == S_OUTPUT);
  assign out_sum    = r_out_sum;
  assign out_ovf    = r_out_ovf;
  assign elem_count = w_elem;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl: job-level arithmetic model, per-cycle
// output compare, and a result scoreboard.
module tb_dot_product_ctrl;

  localparam int N     = 8;
  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start, abort, s_valid, out_ready;
  logic [LEN_W-1:0] length;
  logic [31:0]      tree_sum;
  logic             busy, s_ready, out_valid, out_ovf;
  logic [31:0]      out_sum;
  logic [LEN_W+7:0] elem_count;
  logic [1:0]       dbg_state;

  dot_product_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length), .abort(abort),
    .busy(busy), .s_valid(s_valid), .s_ready(s_ready), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .elem_count(elem_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  logic             chk_en = 1'b0;
  logic             e_busy, e_s_ready, e_out_valid, e_sum_chk, e_ovf;
  logic [31:0]      e_sum;
  logic [LEN_W+7:0] e_elem;
  int               m_len, m_beats;
  logic [63:0]      m_total;
  logic [32:0]      exp_q[$];

  task automatic set_idle_exp();
    e_busy = 1'b0; e_s_ready = 1'b0; e_out_valid = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(e_busy));
      check("s_ready", 64'(s_ready), 64'(e_s_ready));
      check("out_valid", 64'(out_valid), 64'(e_out_valid));
      check("elem_count", 64'(elem_count), 64'(e_elem));
      if (e_sum_chk) begin
        check("out_sum", 64'(out_sum), 64'(e_sum));
        check("out_ovf", 64'(out_ovf), 64'(e_ovf));
      end
    end
  end

  // ---------------- result scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(1), 64'(0));
      end else begin
        logic [32:0] exp_r;
        exp_r = exp_q.pop_front();
        check("sb_result", 64'({out_ovf, out_sum}), 64'(exp_r));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start = 1'b1; length = LEN_W'(len);
    tick();
    start = 1'b0;
    m_len = len; m_beats = 0; m_total = '0;
    e_busy = 1'b1; e_elem = '0;
    if (len == 0) begin
      e_s_ready = 1'b0; e_out_valid = 1'b1;
      e_sum_chk = 1'b1; e_sum = '0; e_ovf = 1'b0;
      exp_q.push_back(33'd0);
    end else begin
      e_s_ready = 1'b1; e_out_valid = 1'b0; e_sum_chk = 1'b0;
    end
  endtask

  // One ACCUM cycle; st drives a start (length=1) that must be ignored while busy.
  task automatic beat(input logic v, input logic [31:0] d, input logic ab, input logic st);
    s_valid = v; tree_sum = d; abort = ab; start = st;
    if (st) length = LEN_W'(1);
    tick();
    s_valid = 1'b0; abort = 1'b0; start = 1'b0; tree_sum = $urandom;
    if (ab) begin
      set_idle_exp();
      e_sum_chk = 1'b0;
    end else if (v) begin
      m_beats++;
      m_total = m_total + 64'(d);
      e_elem = (LEN_W+8)'(m_beats * N);
      if (m_beats == m_len) begin
        e_s_ready = 1'b0; e_out_valid = 1'b1; e_sum_chk = 1'b1;
        e_sum = m_total[31:0];
        e_ovf = (m_total >= 64'h1_0000_0000);
        exp_q.push_back({e_ovf, e_sum});
      end
    end
  endtask

  task automatic finish_job(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    set_idle_exp();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; out_ready = 1'b0;
    length = '0; tree_sum = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_elem", 64'(elem_count), 64'(0));
    tick();
    rst_n = 1'b1;
    set_idle_exp();
    e_elem = '0; e_sum_chk = 1'b1; e_sum = '0; e_ovf = 1'b0;
    chk_en = 1'b1;
    tick();

    // 3 beats, with a start attempt mid-job that must not reload the length
    start_job(3);
    beat(1'b1, 32'd10, 1'b0, 1'b0);
    beat(1'b1, 32'd20, 1'b0, 1'b1);
    beat(1'b1, 32'd30, 1'b0, 1'b0);
    check("lit_sum_60", 64'(out_sum), 64'd60);
    check("lit_ovf_0", 64'(out_ovf), 64'd0);
    check("lit_elem_24", 64'(elem_count), 64'd24);
    finish_job(0);

    // stalls carry junk tree_sum values
    start_job(2);
    beat(1'b1, 32'd5, 1'b0, 1'b0);
    beat(1'b0, 32'd99, 1'b0, 1'b0);
    beat(1'b0, 32'd99, 1'b0, 1'b0);
    beat(1'b1, 32'd5, 1'b0, 1'b0);
    check("lit_sum_10", 64'(out_sum), 64'd10);
    finish_job(1);

    // unsigned wrap with sticky carry
    start_job(2);
    beat(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    beat(1'b1, 32'h0000_0020, 1'b0, 1'b0);
    check("lit_sum_wrap", 64'(out_sum), 64'h10);
    check("lit_ovf_1", 64'(out_ovf), 64'd1);
    finish_job(0);

    // zero-length job straight to OUTPUT, consumer back-pressure for 4 cycles
    start_job(0);
    check("lit_len0_valid", 64'(out_valid), 64'd1);
    check("lit_len0_sum", 64'(out_sum), 64'd0);
    finish_job(4);
    tick();

    // abort after one of four beats; abort-cycle beat is dropped
    start_job(4);
    beat(1'b1, 32'd3, 1'b0, 1'b0);
    beat(1'b1, 32'd100, 1'b1, 1'b0);
    check("lit_abort_elem", 64'(elem_count), 64'd8);
    tick();
    start_job(1);
    beat(1'b1, 32'd7, 1'b0, 1'b0);
    check("lit_sum_7", 64'(out_sum), 64'd7);
    finish_job(0);

    // asynchronous reset mid-ACCUM after a start attempt while busy
    start_job(4);
    beat(1'b1, 32'd1, 1'b0, 1'b0);
    beat(1'b0, 32'd0, 1'b0, 1'b1);
    start = 1'b1; length = LEN_W'(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_s_ready", 64'(s_ready), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_sum", 64'(out_sum), 64'd0);
    check("arst_out_ovf", 64'(out_ovf), 64'd0);
    check("arst_elem", 64'(elem_count), 64'd0);
    set_idle_exp();
    e_elem = '0; e_sum_chk = 1'b1; e_sum = '0; e_ovf = 1'b0;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    check("results_drained", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
